oam_dma_controller: RTL and testbench

- Upstream bus master and CPU-stall source for the CPU core.
- Snoops CPU writes for a store to the OAM DMA register ($4014). On a hit it takes the CPU memory bus and raises cpu_halt, which drives the halt input of the instruction engine and the interrupt handler.
- Copies 256 bytes from page {data,00}..{data,FF} into the PPU OAM data port ($2004), then releases the bus.
- dma_active is the select line of the CPU bus mux, placed ahead of the IE/interrupt-handler mux.

---
 rtl/oam_dma_controller.sv | 148 ++++++++++++++
 tb/tb_oam_dma_controller.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: snoops CPU stores to the DMA trigger register, halts the
// CPU, and copies one 256-byte page into the PPU OAM data port.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   snoop_addr        CPU bus address from the IE / interrupt handler
//   snoop_data_out    CPU write data on that bus
//   snoop_write_en    CPU write strobe on that bus
//   dma_addr          registered DMA bus address
//   dma_data_in       bus read data (valid two edges after dma_addr)
//   dma_data_out      registered DMA bus write data
//   dma_write_en      registered DMA bus write strobe
//   dma_active        CPU bus mux select (engine busy)
//   cpu_halt          stall for IE and interrupt handler
//   dma_done          one-cycle pulse in the final engine cycle
module oam_dma_controller #(
   parameter logic [15:0] DMA_TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] OAM_PORT_ADDR    = 16'h2004,
   parameter int          XFER_LEN         = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] snoop_addr,
   input  logic [7:0]  snoop_data_out,
   input  logic        snoop_write_en,
   output logic [15:0] dma_addr,
   input  logic [7:0]  dma_data_in,
   output logic [7:0]  dma_data_out,
   output logic        dma_write_en,
   output logic        dma_active,
   output logic        cpu_halt,
   output logic        dma_done
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HALT  = 3'd1;
   localparam logic [2:0] S_ALIGN = 3'd2;
   localparam logic [2:0] S_GET   = 3'd3;
   localparam logic [2:0] S_WAIT  = 3'd4;
   localparam logic [2:0] S_PUT   = 3'd5;
   localparam logic [2:0] S_DONE  = 3'd6;

   localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

   logic [2:0]  state_q, state_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic [7:0]  page_q, page_d;
   logic [7:0]  idx_q, idx_d;
   logic        align_q, align_d;
   logic        odd_q, odd_d;

   logic trigger;

   assign trigger = snoop_write_en
                 && (snoop_addr == DMA_TRIGGER_ADDR);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      page_d  = page_q;
      idx_d   = idx_q;
      align_d = align_q;
      odd_d   = ~odd_q;
      unique case (state_q)
         S_IDLE: begin
            if (trigger) begin
               page_d  = snoop_data_out;
               idx_d   = 8'h00;
               // extra dummy cycle when the trigger
               // lands on an odd (put) cycle
               align_d = odd_q;
               state_d = S_HALT;
            end
         end
         S_HALT: begin
            state_d = align_q ? S_ALIGN : S_GET;
         end
         S_ALIGN: begin
            state_d = S_GET;
         end
         S_GET: begin
            addr_d  = {page_q, idx_q};
            we_d    = 1'b0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_PUT;
         end
         S_PUT: begin
            wdata_d = dma_data_in;
            addr_d  = OAM_PORT_ADDR;
            we_d    = 1'b1;
            // wraps within the page; page never advances
            idx_d   = idx_q + 8'd1;
            state_d = (idx_q == LAST_IDX) ? S_DONE : S_GET;
         end
         S_DONE: begin
            we_d    = 1'b0;
            addr_d  = 16'h0000;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
            addr_d  = 16'h0000;
            wdata_d = 8'h00;
            we_d    = 1'b0;
            page_d  = 8'h00;
            idx_d   = 8'h00;
            align_d = 1'b0;
            odd_d   = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         addr_q  <= 16'h0000;
         wdata_q <= 8'h00;
         we_q    <= 1'b0;
         page_q  <= 8'h00;
         idx_q   <= 8'h00;
         align_q <= 1'b0;
         odd_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         page_q  <= page_d;
         idx_q   <= idx_d;
         align_q <= align_d;
         odd_q   <= odd_d;
      end
   end

   assign dma_addr     = addr_q;
   assign dma_data_out = wdata_q;
   assign dma_write_en = we_q;
   assign dma_active   = (state_q != S_IDLE);
   assign cpu_halt     = dma_active;
   assign dma_done     = (state_q == S_DONE);

endmodule

// File: tb/tb_oam_dma_controller.sv
// Bench for oam_dma_controller: memory model, cycle-level reference
// model with per-cycle compare, and directed transfer scenarios.
module tb_oam_dma_controller;

   logic        clk;
   logic        rst;
   logic [15:0] snoop_addr;
   logic [7:0]  snoop_data_out;
   logic        snoop_write_en;
   logic [15:0] dma_addr;
   logic [7:0]  dma_data_in;
   logic [7:0]  dma_data_out;
   logic        dma_write_en;
   logic        dma_active;
   logic        cpu_halt;
   logic        dma_done;

   oam_dma_controller dut (
      .clk            (clk),
      .rst            (rst),
      .snoop_addr     (snoop_addr),
      .snoop_data_out (snoop_data_out),
      .snoop_write_en (snoop_write_en),
      .dma_addr       (dma_addr),
      .dma_data_in    (dma_data_in),
      .dma_data_out   (dma_data_out),
      .dma_write_en   (dma_write_en),
      .dma_active     (dma_active),
      .cpu_halt       (cpu_halt),
      .dma_done       (dma_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm,
                      input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // memory: data for an address registered at edge k
   // is presented only from edge k+2 on
   logic [7:0]  mem [0:65535];
   logic [15:0] addr_prev = 16'h0;

   always @(negedge clk) begin
      dma_data_in = mem[addr_prev];
      addr_prev   = dma_addr;
   end

   // observation logs
   logic [7:0]  oam [$];
   logic [15:0] src [$];
   logic [15:0] last_a = 16'h0;
   int act_cnt = 0;
   int done_cnt = 0;

   always @(negedge clk) begin
      if (dma_write_en && dma_addr == 16'h2004)
         oam.push_back(dma_data_out);
      if (dma_addr != last_a) begin
         if (dma_addr != 16'h0 && dma_addr != 16'h2004)
            src.push_back(dma_addr);
         last_a = dma_addr;
      end
      if (dma_active) act_cnt++;
      if (dma_done) done_cnt++;
   end

   // reference model: m_n counts edges since the trigger edge
   bit        m_busy = 1'b0;
   int        m_n = 0;
   bit        m_align = 1'b0;
   logic [7:0] m_page = 8'h0;
   bit        par = 1'b0;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy = 1'b0;
         m_n    = 0;
         par    = 1'b0;
      end else begin
         if (m_busy) begin
            m_n++;
            if (m_n == 770 + int'(m_align)) m_busy = 1'b0;
         end else if (snoop_write_en
                   && snoop_addr == 16'h4014) begin
            m_busy  = 1'b1;
            m_n     = 0;
            m_page  = snoop_data_out;
            m_align = par;
         end
         par = ~par;
      end
   end

   always @(negedge clk) begin
      logic [15:0] ea;
      logic        ew;
      logic [7:0]  ed;
      logic [7:0]  bi;
      int          s;
      ea = 16'h0;
      ew = 1'b0;
      ed = 8'h0;
      bi = 8'h0;
      s  = -1;
      if (m_busy) begin
         // bytes start after HALT (+ALIGN), 3 cycles each
         s = m_n - 2 - int'(m_align);
         if (s >= 0) begin
            bi = 8'(s / 3);
            if (s % 3 == 2) begin
               ea = 16'h2004;
               ew = 1'b1;
               ed = mem[{m_page, bi}];
            end else begin
               ea = {m_page, bi};
            end
         end
      end
      chk("active", 32'(dma_active), 32'(m_busy));
      chk("halt", 32'(cpu_halt), 32'(m_busy));
      chk("done", 32'(dma_done),
          32'(m_busy && m_n == 769 + int'(m_align)));
      chk("we", 32'(dma_write_en), 32'(ew));
      chk("addr", 32'(dma_addr), 32'(ea));
      if (ew) chk("wdata", 32'(dma_data_out), 32'(ed));
   end

   task automatic clr();
      oam.delete();
      src.delete();
      act_cnt  = 0;
      done_cnt = 0;
   endtask

   task automatic cpu_wr(input logic [15:0] a,
                         input logic [7:0] d);
      snoop_write_en = 1'b1;
      snoop_addr     = a;
      snoop_data_out = d;
      @(negedge clk);
      snoop_write_en = 1'b0;
      snoop_addr     = 16'h0;
      snoop_data_out = 8'h0;
   endtask

   task automatic trig(input logic [7:0] pg, input bit want);
      @(negedge clk);
      if (par != want) @(negedge clk);
      cpu_wr(16'h4014, pg);
   endtask

   task automatic wait_idle(input string nm);
      int k;
      k = 0;
      @(negedge clk);
      while ((m_busy || dma_active) && k < 2000) begin
         @(negedge clk);
         k++;
      end
      chk({nm, "_timeout"}, 32'(k < 2000), 32'd1);
   endtask

   task automatic wait_bytes(input int n, input string nm);
      int k;
      k = 0;
      while (oam.size() < n && k < 2000) begin
         @(negedge clk);
         k++;
      end
      #1;
      chk({nm, "_bytes"}, 32'(oam.size()), 32'(n));
   endtask

   initial begin
      int bad;
      rst            = 1'b0;
      snoop_addr     = 16'h0;
      snoop_data_out = 8'h0;
      snoop_write_en = 1'b0;
      dma_data_in    = 8'h0;
      for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
      for (int i = 0; i < 256; i++) begin
         mem[16'h0200 + i] = 8'(i) ^ 8'h5A;
         mem[16'h0300 + i] = 8'(i) ^ 8'hC3;
         mem[16'hFF00 + i] = 8'(i) ^ 8'h3C;
      end

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_active", 32'(dma_active), 32'd0);
      chk("rst_halt", 32'(cpu_halt), 32'd0);
      chk("rst_done", 32'(dma_done), 32'd0);
      chk("rst_we", 32'(dma_write_en), 32'd0);
      chk("rst_addr", 32'(dma_addr), 32'd0);
      chk("rst_wdata", 32'(dma_data_out), 32'd0);
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // non-trigger writes
      clr();
      cpu_wr(16'h4015, 8'h02);
      cpu_wr(16'h2004, 8'h02);
      repeat (10) @(negedge clk);
      chk("nt_act", 32'(act_cnt), 32'd0);
      chk("nt_oam", 32'(oam.size()), 32'd0);

      // even parity
      clr();
      trig(8'h02, 1'b0);
      wait_idle("even");
      chk("even_len", 32'(act_cnt), 32'd770);
      chk("even_done", 32'(done_cnt), 32'd1);
      chk("even_n", 32'(oam.size()), 32'd256);
      chk("even_d0", 32'(oam[0]), 32'h5A);
      chk("even_d1", 32'(oam[1]), 32'h5B);
      chk("even_d255", 32'(oam[255]), 32'hA5);
      chk("even_src0", 32'(src[0]), 32'h0200);

      // odd parity
      clr();
      trig(8'h02, 1'b1);
      wait_idle("odd");
      chk("odd_len", 32'(act_cnt), 32'd771);
      chk("odd_done", 32'(done_cnt), 32'd1);
      chk("odd_n", 32'(oam.size()), 32'd256);
      chk("odd_d0", 32'(oam[0]), 32'h5A);
      chk("odd_d255", 32'(oam[255]), 32'hA5);

      // page FF stays within the page
      clr();
      trig(8'hFF, 1'b0);
      wait_idle("wrap");
      chk("wrap_nsrc", 32'(src.size()), 32'd256);
      chk("wrap_last", 32'(src[255]), 32'hFFFF);
      bad = 0;
      foreach (src[i]) if (src[i][15:8] != 8'hFF) bad++;
      chk("wrap_out", 32'(bad), 32'd0);
      chk("wrap_d0", 32'(oam[0]), 32'h3C);
      chk("wrap_d255", 32'(oam[255]), 32'hC3);

      // retrigger mid-transfer is ignored
      clr();
      trig(8'h02, 1'b0);
      wait_bytes(100, "rt");
      @(negedge clk);
      cpu_wr(16'h4014, 8'h03);
      wait_idle("rt");
      repeat (30) @(negedge clk);
      chk("rt_done", 32'(done_cnt), 32'd1);
      chk("rt_len", 32'(act_cnt), 32'd770);
      chk("rt_n", 32'(oam.size()), 32'd256);
      bad = 0;
      foreach (src[i]) if (src[i][15:8] != 8'h02) bad++;
      foreach (oam[i])
         if (oam[i] != (8'(i) ^ 8'h5A)) bad++;
      chk("rt_bad", 32'(bad), 32'd0);

      // reset mid-transfer
      clr();
      trig(8'h02, 1'b0);
      @(negedge clk);
      wait_bytes(40, "mr");
      rst = 1'b0;
      #1;
      chk("mr_active", 32'(dma_active), 32'd0);
      chk("mr_halt", 32'(cpu_halt), 32'd0);
      chk("mr_we", 32'(dma_write_en), 32'd0);
      chk("mr_addr", 32'(dma_addr), 32'd0);
      chk("mr_wdata", 32'(dma_data_out), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (50) @(negedge clk);
      chk("mr_n", 32'(oam.size()), 32'd40);
      chk("mr_done", 32'(done_cnt), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
